// File: rtl/mau_pkg.sv
// ============================================================================
// Module  : mau_pkg
// Purpose : Shared size encodings, FSM states and alignment helper for the
//           memory access unit.
// Revision: 1.0
// ============================================================================
`default_nettype none

package mau_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_DONE = 2'b10,
        ST_ERR  = 2'b11
    } mau_state_e;

    // Reserved size is reported as misaligned so one test covers both faults.
    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] addr_lsbs);
        logic ok;
        case (size)
            SZ_BYTE: ok = 1'b1;
            SZ_HALF: ok = ~addr_lsbs[0];
            SZ_WORD: ok = (addr_lsbs == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mau_lane_ext.sv
// ============================================================================
// Module  : mau_lane_ext
// Purpose : Selects byte/halfword/word from four little-endian bytes and
//           sign- or zero-extends it to 32 bits.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mau_lane_ext
    import mau_pkg::*;
(
    input  logic [31:0] i_bytes,
    input  logic [1:0]  i_size,
    input  logic        i_sgn_en,
    output logic [31:0] o_data
);

    always_comb begin
        o_data = i_bytes;
        case (i_size)
            SZ_BYTE: o_data = {{24{i_sgn_en & i_bytes[7]}},  i_bytes[7:0]};
            SZ_HALF: o_data = {{16{i_sgn_en & i_bytes[15]}}, i_bytes[15:0]};
            default: o_data = i_bytes;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ============================================================================
// Module  : mem_access_unit
// Purpose : Byte-addressed RAM with MFA/MFC handshake, wait states, size
//           selection, load extension and alignment fault reporting.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_access_unit
    import mau_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2,
    parameter     INIT_FILE   = ""
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              MFA,
    input  logic              RW,
    input  logic [1:0]        SIZE,
    input  logic              SGN_EN,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [31:0]       WDATA,
    output logic [31:0]       RDATA,
    output logic              MFC,
    output logic              BUSY,
    output logic              FAULT
);

    localparam int DEPTH = 2 ** ADDR_W;

    mau_state_e        state_q, state_d;
    logic              hold_q, hold_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rw_q, rw_d;
    logic [1:0]        size_q, size_d;
    logic              sgn_q, sgn_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;

    logic              w_do_access;
    logic [3:0]        w_lane_en;
    logic [31:0]       w_rd_bytes;
    logic [31:0]       w_rd_ext;
    logic [ADDR_W-1:0] w_lane_addr [4];

    logic [7:0]        mem [DEPTH];

    // Lane i is byte addr+i, wrapping at the top of the array.
    for (genvar i = 0; i < 4; i++) begin : g_lane
        assign w_lane_addr[i]      = addr_q + ADDR_W'(i);
        assign w_rd_bytes[8*i +: 8] = mem[w_lane_addr[i]];
    end

    mau_lane_ext u_lane_ext (
        .i_bytes  (w_rd_bytes),
        .i_size   (size_q),
        .i_sgn_en (sgn_q),
        .o_data   (w_rd_ext)
    );

    always_comb begin
        case (size_q)
            SZ_BYTE: w_lane_en = 4'b0001;
            SZ_HALF: w_lane_en = 4'b0011;
            default: w_lane_en = 4'b1111;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        rw_d        = rw_q;
        size_d      = size_q;
        sgn_d       = sgn_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        w_do_access = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (MFA) begin
                    addr_d  = ADDR;
                    rw_d    = RW;
                    size_d  = SIZE;
                    sgn_d   = SGN_EN;
                    wdata_d = WDATA;
                    if (!is_aligned(SIZE, ADDR[1:0])) begin
                        state_d = ST_ERR;
                        hold_d  = 1'b0;
                    end else begin
                        cnt_d   = 4'(WAIT_CYCLES);
                        state_d = ST_WAIT;
                    end
                end
            end
            // The access fires on the edge after the wait budget is spent,
            // giving MFC exactly WAIT_CYCLES+1 edges after the sample.
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    w_do_access = 1'b1;
                    state_d     = ST_DONE;
                    if (rw_q) begin
                        rdata_d = w_rd_ext;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DONE: begin
                if (!MFA) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ERR: begin
                if (!MFA) begin
                    state_d = ST_IDLE;
                    hold_d  = 1'b0;
                end else begin
                    hold_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!CLR) begin
            state_q <= ST_IDLE;
            hold_q  <= 1'b0;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            rw_q    <= 1'b0;
            size_q  <= SZ_BYTE;
            sgn_q   <= 1'b0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            rw_q    <= rw_d;
            size_q  <= size_d;
            sgn_q   <= sgn_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // A reset on the access edge suppresses the pending write.
    always_ff @(posedge CLK) begin
        if (CLR && w_do_access && !rw_q) begin
            for (int i = 0; i < 4; i++) begin
                if (w_lane_en[i]) begin
                    mem[w_lane_addr[i]] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    assign RDATA = rdata_q;
    assign MFC   = (state_q == ST_DONE);
    assign BUSY  = (state_q == ST_WAIT) || ((state_q == ST_ERR) && !hold_q);
    assign FAULT = (state_q == ST_ERR) && !hold_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// ============================================================================
// Module  : tb_mem_access_unit
// Purpose : Scoreboard bench for mem_access_unit (instance 0: ADDR_W=8,
//           WAIT_CYCLES=2; instance 1: ADDR_W=4, WAIT_CYCLES=0).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_access_unit;

    localparam int WAITS [2] = '{2, 0};
    localparam int DEPTHS[2] = '{256, 16};

    typedef struct {
        int          inst;
        bit          is_fault;
        logic [31:0] exp_rdata;
        int          exp_edge;
    } item_t;

    logic        clk;
    logic        clr   [2];
    logic        mfa   [2];
    logic        rw    [2];
    logic [1:0]  size  [2];
    logic        sgn   [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata [2];
    logic        mfc   [2];
    logic        busy  [2];
    logic        fault [2];
    logic [7:0]  addr0;
    logic [3:0]  addr1;

    int          edge_cnt = 0;
    int          n_pass   = 0;
    int          n_total  = 0;
    item_t       sb [$];

    bit   [7:0]  ref_mem   [2][256];
    logic [31:0] ref_rdata [2];

    mem_access_unit #(.ADDR_W(8), .WAIT_CYCLES(2), .INIT_FILE("")) u_dut0 (
        .CLK(clk), .CLR(clr[0]), .MFA(mfa[0]), .RW(rw[0]), .SIZE(size[0]),
        .SGN_EN(sgn[0]), .ADDR(addr0), .WDATA(wdata[0]), .RDATA(rdata[0]),
        .MFC(mfc[0]), .BUSY(busy[0]), .FAULT(fault[0])
    );

    mem_access_unit #(.ADDR_W(4), .WAIT_CYCLES(0), .INIT_FILE("")) u_dut1 (
        .CLK(clk), .CLR(clr[1]), .MFA(mfa[1]), .RW(rw[1]), .SIZE(size[1]),
        .SGN_EN(sgn[1]), .ADDR(addr1), .WDATA(wdata[1]), .RDATA(rdata[1]),
        .MFC(mfc[1]), .BUSY(busy[1]), .FAULT(fault[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
    endtask

    // Reference read: assemble bytes arithmetically, then extend by value range.
    function automatic logic [31:0] model_read(int k, int a, int sz, bit s);
        longint v  = 0;
        int     nb = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
        for (int i = 0; i < nb; i++)
            v += longint'(ref_mem[k][(a + i) % DEPTHS[k]]) * (longint'(1) << (8 * i));
        if (nb < 4 && s && v >= (longint'(1) << (8 * nb - 1)))
            v -= (longint'(1) << (8 * nb));
        return v[31:0];
    endfunction

    task automatic issue(input int k, input bit rw_i, input bit [1:0] sz, input bit s,
                         input int a, input logic [31:0] wd, input int hold);
        item_t it;
        bit    aligned;
        bit    got;
        int    nb;
        @(negedge clk);
        rw[k] = rw_i; size[k] = sz; sgn[k] = s; wdata[k] = wd;
        if (k == 0) addr0 = 8'(a); else addr1 = 4'(a);
        mfa[k] = 1'b1;
        aligned = (sz == 0) || (sz == 1 && a % 2 == 0) || (sz == 2 && a % 4 == 0);
        it.inst     = k;
        it.is_fault = !aligned;
        it.exp_edge = aligned ? edge_cnt + 1 + WAITS[k] + 1 : edge_cnt + 1;
        if (aligned) begin
            if (rw_i) begin
                ref_rdata[k] = model_read(k, a, sz, s);
            end else begin
                nb = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
                for (int i = 0; i < nb; i++)
                    ref_mem[k][(a + i) % DEPTHS[k]] = wd[8*i +: 8];
            end
        end
        it.exp_rdata = ref_rdata[k];
        sb.push_back(it);

        got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            if (mfc[k] || fault[k]) got = 1'b1;
        end
        if (!got) begin
            n_total++;
            $display("FAIL response_timeout: inst %0d got no MFC/FAULT expected one", k);
        end
        repeat (hold) begin
            @(negedge clk);
            check("mfc_while_mfa", {31'd0, mfc[k]}, {31'd0, aligned});
        end
        mfa[k] = 1'b0;
        @(negedge clk);
        check("mfc_after_release", {31'd0, mfc[k]}, 32'd0);
    endtask

    // Scoreboard monitor: a rising MFC or FAULT consumes one expected response.
    bit   mfc_prev [2]  = '{1'b0, 1'b0};
    bit   flt_prev [2]  = '{1'b0, 1'b0};
    bit   flt_chk  [2]  = '{1'b0, 1'b0};
    always @(negedge clk) begin
        item_t it;
        for (int k = 0; k < 2; k++) begin
            if (flt_chk[k]) begin
                check("fault_width", {31'd0, fault[k]}, 32'd0);
                flt_chk[k] = 1'b0;
            end
            if ((mfc[k] && !mfc_prev[k]) || (fault[k] && !flt_prev[k])) begin
                if (sb.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_response: inst %0d mfc=%0b fault=%0b expected none",
                             k, mfc[k], fault[k]);
                end else begin
                    it = sb.pop_front();
                    check("resp_inst",  32'(k), 32'(it.inst));
                    check("resp_fault", {31'd0, fault[k]}, {31'd0, it.is_fault});
                    check("resp_mfc",   {31'd0, mfc[k]},   {31'd0, !it.is_fault});
                    check("resp_edge",  32'(edge_cnt),     32'(it.exp_edge));
                    check("resp_rdata", rdata[k],          it.exp_rdata);
                    if (fault[k]) flt_chk[k] = 1'b1;
                end
            end
            mfc_prev[k] = mfc[k];
            flt_prev[k] = fault[k];
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            clr[k] = 1'b0; mfa[k] = 1'b0; rw[k] = 1'b0; size[k] = 2'b00;
            sgn[k] = 1'b0; wdata[k] = 32'd0; ref_rdata[k] = 32'd0;
        end
        addr0 = 8'd0; addr1 = 4'd0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("reset_mfc",   {31'd0, mfc[k]},   32'd0);
            check("reset_busy",  {31'd0, busy[k]},  32'd0);
            check("reset_fault", {31'd0, fault[k]}, 32'd0);
            check("reset_rdata", rdata[k],          32'd0);
        end
        clr[0] = 1'b1; clr[1] = 1'b1;

        for (int a = 0; a < 256; a += 4) issue(0, 1'b0, 2'b10, 1'b0, a, $urandom, 0);
        for (int a = 0; a < 16;  a += 4) issue(1, 1'b0, 2'b10, 1'b0, a, $urandom, 0);

        issue(0, 1'b0, 2'b10, 1'b0, 'h10, 32'h8899AABB, 0);
        issue(0, 1'b1, 2'b10, 1'b0, 'h10, 32'd0, 0);
        check("plan_word_read",  rdata[0], 32'h8899AABB);
        issue(0, 1'b1, 2'b00, 1'b1, 'h11, 32'd0, 0);
        check("plan_byte_sext",  rdata[0], 32'hFFFFFFAA);
        issue(0, 1'b1, 2'b00, 1'b0, 'h11, 32'd0, 0);
        check("plan_byte_zext",  rdata[0], 32'h000000AA);
        issue(0, 1'b1, 2'b01, 1'b1, 'h12, 32'd0, 0);
        check("plan_half_sext",  rdata[0], 32'hFFFF8899);
        issue(0, 1'b1, 2'b10, 1'b0, 'h13, 32'd0, 0);
        issue(0, 1'b0, 2'b11, 1'b0, 'h10, 32'hDEADBEEF, 3);
        issue(0, 1'b1, 2'b10, 1'b0, 'h10, 32'd0, 0);
        check("fault_mem_kept",  rdata[0], 32'h8899AABB);
        issue(0, 1'b0, 2'b00, 1'b0, 'h20, 32'h0000005A, 10);
        issue(0, 1'b1, 2'b00, 1'b0, 'h20, 32'd0, 0);

        // Reset while a word write to 0x40 is waiting.
        @(negedge clk);
        rw[0] = 1'b0; size[0] = 2'b10; sgn[0] = 1'b0; addr0 = 8'h40;
        wdata[0] = 32'h12345678; mfa[0] = 1'b1;
        @(negedge clk);
        check("abort_busy_before", {31'd0, busy[0]}, 32'd1);
        clr[0] = 1'b0;
        @(negedge clk);
        check("abort_mfc",   {31'd0, mfc[0]},  32'd0);
        check("abort_busy",  {31'd0, busy[0]}, 32'd0);
        check("abort_rdata", rdata[0],         32'd0);
        clr[0] = 1'b1; mfa[0] = 1'b0; ref_rdata[0] = 32'd0;
        issue(0, 1'b1, 2'b10, 1'b0, 'h40, 32'd0, 0);

        issue(1, 1'b0, 2'b00, 1'b0, 'hF, 32'h000000C3, 0);
        issue(1, 1'b1, 2'b00, 1'b1, 'hF, 32'd0, 0);
        check("small_byte_sext", rdata[1], 32'hFFFFFFC3);
        issue(1, 1'b1, 2'b00, 1'b0, 'h0, 32'd0, 0);
        issue(1, 1'b1, 2'b10, 1'b0, 'hC, 32'd0, 1);
        issue(1, 1'b1, 2'b01, 1'b1, 'hE, 32'd0, 0);

        for (int n = 0; n < 120; n++) begin
            int       k;
            int       a;
            bit [1:0] sz;
            k  = $urandom_range(0, 1);
            sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            a  = $urandom_range(0, DEPTHS[k] - 1);
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'b01) a = a & ~1;
                if (sz == 2'b10) a = a & ~3;
            end
            issue(k, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a,
                  $urandom, $urandom_range(0, 3));
        end

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
